addsub_calc_display: RTL and testbench

//  Parametrised successor to the 8-bit-entry add/sub display block. Operands A and B are entered

---
 rtl/addsub_calc_display.sv | 215 +++++++++++++++++++++
 tb/tb_addsub_calc_display.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_calc_display.sv
// Byte-entry add/subtract calculator with a paged, multiplexed 7-segment display.
// Optional macro ADDSUB_SIGNED_DISPLAY_EN: show the result as sign + magnitude.
module addsub_calc_display #(
    parameter int WIDTH         = 32,
    parameter int DIGITS        = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int PAGE_INTERVAL = 100000000,
    localparam int BSW          = (WIDTH / 8 > 1) ? $clog2(WIDTH / 8) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [7:0]        din,
    input  logic [BSW-1:0]    byte_sel,
    input  logic              load,
    input  logic              next,
    input  logic              addorsub,
    output logic              carry,
    output logic              over,
    output logic [1:0]        state,
    output logic [DIGITS-1:0] sm_wei,
    output logic [6:0]        sm_duan,
    output logic              showSign
);

    localparam int BYTES = WIDTH / 8;
    localparam int NIBS  = WIDTH / 4;
    localparam int PAGES = (NIBS + DIGITS - 1) / DIGITS;
    localparam int PADW  = PAGES * DIGITS * 4;
    localparam int SCW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PCW   = (PAGE_INTERVAL > 1) ? $clog2(PAGE_INTERVAL) : 1;
    localparam int IDXW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PGW   = (PAGES > 1) ? $clog2(PAGES) : 1;

    typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_CALC = 2'd2, S_RES = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
    logic               carry_q, carry_d, over_q, over_d;
    logic               load_q, next_q, load_p_q, next_p_q;
    logic [7:0]         din_q;
    logic [BSW-1:0]     sel_q;
    logic               sel_ok;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   r_disp, disp_src;
    logic [PADW-1:0]    src_pad;
    logic [31:0]        nib_pos;
    logic [3:0]         nibble;
    logic [SCW-1:0]     scan_cnt_q;
    logic [IDXW-1:0]    idx_q;
    logic [PCW-1:0]     page_cnt_q;
    logic [PGW-1:0]     page_q;
    logic [DIGITS-1:0]  sm_wei_q;
    logic [6:0]         sm_duan_q;

    function automatic logic [6:0] seg_font(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
            4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
            4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
            4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
        endcase
        return ~s;
    endfunction

    // Input levels are registered once; the pulse (and its din/byte_sel) act one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q   <= 1'b0;
            next_q   <= 1'b0;
            load_p_q <= 1'b0;
            next_p_q <= 1'b0;
            din_q    <= '0;
            sel_q    <= '0;
        end else begin
            load_q   <= load;
            next_q   <= next;
            load_p_q <= load & ~load_q;
            next_p_q <= next & ~next_q;
            din_q    <= din;
            sel_q    <= byte_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A:     if (next_p_q) state_d = S_B;
            S_B:     if (next_p_q) state_d = S_CALC;
            S_CALC:  state_d = S_RES;
            default: if (next_p_q) state_d = S_A;
        endcase
    end

    always_comb begin
        state    = state_q;
        disp_src = r_disp;
        case (state_q)
            S_A:     disp_src = a_q;
            S_B:     disp_src = b_q;
            default: ;
        endcase
    end

    assign sel_ok = 32'(sel_q) < BYTES;
    assign b_eff  = addorsub ? ~b_q : b_q;
    assign sum    = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, addorsub};

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        carry_d = carry_q;
        over_d  = over_q;
        case (state_q)
            S_A: if (load_p_q && sel_ok) a_d[8*sel_q +: 8] = din_q;
            S_B: if (load_p_q && sel_ok) b_d[8*sel_q +: 8] = din_q;
            S_CALC: begin
                r_d     = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                over_d  = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            default: if (next_p_q) begin
                a_d     = '0;
                b_d     = '0;
                r_d     = '0;
                carry_d = 1'b0;
                over_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            over_q  <= over_d;
        end
    end

    assign carry = carry_q;
    assign over  = over_q;

`ifdef ADDSUB_SIGNED_DISPLAY_EN
    logic in_res;
    assign in_res   = (state_q == S_CALC) || (state_q == S_RES);
    // Negating the most-negative value wraps to itself, which reads correctly as a magnitude.
    assign r_disp   = r_q[WIDTH-1] ? ({WIDTH{1'b0}} - r_q) : r_q;
    assign showSign = in_res & r_q[WIDTH-1];
`else
    assign r_disp   = r_q;
    assign showSign = 1'b0;
`endif

    assign src_pad = PADW'(disp_src);
    assign nib_pos = 32'(page_q) * DIGITS + 32'(idx_q);
    assign nibble  = src_pad[4*nib_pos +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            page_cnt_q <= '0;
            page_q     <= '0;
            sm_wei_q   <= '1;
            sm_duan_q  <= 7'h7F;
        end else begin
            if (en) begin
                if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
                    scan_cnt_q <= '0;
                    idx_q      <= (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
                end else begin
                    scan_cnt_q <= scan_cnt_q + 1'b1;
                end
            end
            if (state_d != state_q) begin
                page_cnt_q <= '0;
                page_q     <= '0;
            end else if (en) begin
                if (page_cnt_q == PCW'(PAGE_INTERVAL - 1)) begin
                    page_cnt_q <= '0;
                    page_q     <= (page_q == PGW'(PAGES - 1)) ? '0 : page_q + 1'b1;
                end else begin
                    page_cnt_q <= page_cnt_q + 1'b1;
                end
            end
            if (en) begin
                sm_wei_q  <= ~(DIGITS'(1) << idx_q);
                sm_duan_q <= seg_font(nibble);
            end else begin
                sm_wei_q  <= '1;
                sm_duan_q <= 7'h7F;
            end
        end
    end

    assign sm_wei  = sm_wei_q;
    assign sm_duan = sm_duan_q;

endmodule

// File: tb/tb_addsub_calc_display.sv
// Randomised self-checking bench for addsub_calc_display (WIDTH=32, DIGITS=4, SCAN_DIV=4, PAGE_INTERVAL=64).
// Define ADDSUB_SIGNED_DISPLAY_EN for both files to exercise the sign-magnitude display.
module tb_addsub_calc_display;

    localparam int WIDTH = 32;
    localparam int DIGITS = 4;
    localparam int SCAN_DIV = 4;
    localparam int PAGE_INTERVAL = 64;

    logic        clk = 1'b0;
    logic        rst_n, en, load, next, addorsub;
    logic [7:0]  din;
    logic [1:0]  byte_sel;
    logic        carry, over, showSign;
    logic [1:0]  state;
    logic [3:0]  sm_wei;
    logic [6:0]  sm_duan;

    int total = 0;
    int bad = 0;

    addsub_calc_display #(
        .WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .PAGE_INTERVAL(PAGE_INTERVAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din), .byte_sel(byte_sel),
        .load(load), .next(next), .addorsub(addorsub), .carry(carry), .over(over),
        .state(state), .sm_wei(sm_wei), .sm_duan(sm_duan), .showSign(showSign)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Active-low hex font {g..a}
    function automatic logic [6:0] seg_lo(input int n);
        logic [6:0] s;
        case (n)
            0: s = 7'h3F; 1: s = 7'h06; 2: s = 7'h5B; 3: s = 7'h4F;
            4: s = 7'h66; 5: s = 7'h6D; 6: s = 7'h7D; 7: s = 7'h07;
            8: s = 7'h7F; 9: s = 7'h6F; 10: s = 7'h77; 11: s = 7'h7C;
            12: s = 7'h39; 13: s = 7'h5E; 14: s = 7'h79; default: s = 7'h71;
        endcase
        return ~s;
    endfunction

    task automatic ref_calc(input logic [31:0] a, input logic [31:0] b, input logic op,
                            output logic [31:0] r, output logic c, output logic o);
        longint sa, sb, ss;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op) begin
            r  = a + b;
            c  = (longint'(a) + longint'(b)) > 64'sd4294967295;
            ss = sa + sb;
        end else begin
            r  = a - b;
            c  = (a >= b);
            ss = sa - sb;
        end
        o = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; next = 1'b0; din = '0; byte_sel = '0; addorsub = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_load(input logic [1:0] sel, input logic [7:0] data);
        din = data; byte_sel = sel; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_next();
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_and_next(input logic [1:0] sel, input logic [7:0] data);
        din = data; byte_sel = sel; load = 1'b1; next = 1'b1;
        @(negedge clk);
        load = 1'b0; next = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [1:0] exp, input string tag);
        for (int i = 0; i < 10; i++) begin
            if (state == exp) break;
            @(negedge clk);
        end
        check_val(tag, state, exp);
    endtask

    // Caller raises en right after a negedge; k counts en-cycles since scan/page counters were last zero.
    task automatic show_check(input logic [31:0] val, input int k0, input int k1);
        int idx, page, nib;
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            idx  = ((k - 1) / SCAN_DIV) % DIGITS;
            page = ((k - 1) / PAGE_INTERVAL) % 2;
            nib  = int'((val >> (4 * (page * DIGITS + idx))) & 32'hF);
            check_val($sformatf("wei_k%0d", k), sm_wei, 4'(~(4'b0001 << idx)));
            check_val($sformatf("duan_k%0d", k), sm_duan, seg_lo(nib));
        end
    endtask

    task automatic run_case(input logic [31:0] a, input logic [31:0] b, input logic op,
                            input bit combo, input bit full);
        logic [31:0] r, shown;
        logic c, o, sgn;
        do_reset();
        for (int i = 0; i < 4; i++) pulse_load(i[1:0], a[8*i +: 8]);
        pulse_next();
        wait_state(2'd1, "st_b");
        addorsub = op;
        if (combo) begin
            for (int i = 0; i < 3; i++) pulse_load(i[1:0], b[8*i +: 8]);
            load_and_next(2'd3, b[31:24]);
        end else begin
            for (int i = 0; i < 4; i++) pulse_load(i[1:0], b[8*i +: 8]);
            pulse_next();
        end
        wait_state(2'd3, "st_res");
        ref_calc(a, b, op, r, c, o);
        check_val("carry", carry, c);
        check_val("over", over, o);
`ifdef ADDSUB_SIGNED_DISPLAY_EN
        sgn   = r[31];
        shown = r[31] ? (32'd0 - r) : r;
`else
        sgn   = 1'b0;
        shown = r;
`endif
        if (full) pulse_load(2'd3, 8'hAA);
        en = 1'b1;
        if (full) begin
            show_check(shown, 1, 80);
            en = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check_val("wei_off", sm_wei, 4'hF);
                check_val("duan_off", sm_duan, 7'h7F);
            end
            en = 1'b1;
            show_check(shown, 81, 140);
        end else begin
            show_check(shown, 1, 128);
        end
        check_val("sign", showSign, sgn);
        if (full) begin
            pulse_next();
            wait_state(2'd0, "st_clr");
            @(negedge clk);
            check_val("clr_carry", carry, 1'b0);
            check_val("clr_over", over, 1'b0);
            check_val("clr_duan", sm_duan, seg_lo(0));
            check_val("clr_sign", showSign, 1'b0);
        end
        en = 1'b0;
        $display("case a=%08h b=%08h op=%0d r=%08h c=%0d o=%0d", a, b, op, r, c, o);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        logic rop;
        do_reset();
        check_val("rst_state", state, 2'd0);
        check_val("rst_carry", carry, 1'b0);
        check_val("rst_over", over, 1'b0);
        check_val("rst_wei", sm_wei, 4'hF);
        check_val("rst_duan", sm_duan, 7'h7F);
        check_val("rst_sign", showSign, 1'b0);

        run_case(32'h12345678, 32'h00000001, 1'b0, 1'b0, 1'b1);
        run_case(32'h00000001, 32'h00000002, 1'b1, 1'b0, 1'b0);
        run_case(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0);
        run_case(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run_case(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b0);

        // next held high for 10 cycles must advance exactly once
        do_reset();
        next = 1'b1;
        repeat (10) @(negedge clk);
        next = 1'b0;
        repeat (3) @(negedge clk);
        check_val("next_held", state, 2'd1);
        $display("next held 10 cycles: state=%0d", state);

        // asynchronous reset while in S_CALC
        do_reset();
        en = 1'b1;
        pulse_load(2'd0, 8'h05);
        pulse_next();
        pulse_load(2'd0, 8'h03);
        next = 1'b1;
        @(negedge clk);
        next = 1'b0;
        @(negedge clk);
        wait_state(2'd2, "st_calc");
        rst_n = 1'b0;
        #1;
        check_val("mid_state", state, 2'd0);
        check_val("mid_carry", carry, 1'b0);
        check_val("mid_wei", sm_wei, 4'hF);
        check_val("mid_duan", sm_duan, 7'h7F);
        check_val("mid_sign", showSign, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("post_state", state, 2'd0);
        check_val("post_carry", carry, 1'b0);
        en = 1'b0;
        $display("reset during S_CALC: state=%0d", state);

        for (int it = 0; it < 12; it++) begin
            ra  = $urandom;
            rb  = (it == 0) ? ra : $urandom;
            rop = 1'($urandom_range(0, 1));
            run_case(ra, rb, rop, it[0], 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
